// File: rtl/tdm_scan_mux_if.sv
// Handshake-free channel bus for the TDM scan multiplexer.
// Master drives selection and channel data; slave returns the muxed view.
interface tdm_scan_mux_if #(
    parameter int N_CH  = 4,
    parameter int W     = 4,
    parameter int SEL_W = $clog2(N_CH)
);
    logic              en;
    logic              mode;
    logic [SEL_W-1:0]  sel;
    logic [N_CH-1:0]   ch_mask;
    logic [N_CH*W-1:0] in_bus;
    logic [W-1:0]      out;
    logic [N_CH-1:0]   ch_onehot;
    logic [SEL_W-1:0]  ch_idx;
    logic              wrap;

    modport master (
        output en, mode, sel, ch_mask, in_bus,
        input  out, ch_onehot, ch_idx, wrap
    );

    modport slave (
        input  en, mode, sel, ch_mask, in_bus,
        output out, ch_onehot, ch_idx, wrap
    );
endinterface

// File: rtl/tdm_scan_mux.sv
// Registered N_CH-to-1 channel mux with manual select and
// dwell-timed circular scan over a channel enable mask.
module tdm_scan_mux #(
    parameter int N_CH  = 4,
    parameter int W     = 4,
    parameter int DWELL = 100000,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic           clk,
    input  logic           rst_n,
    tdm_scan_mux_if.slave  bus
);
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] idx_q, idx_d, nxt_idx;
    logic [W-1:0]     out_q, out_d;
    logic [N_CH-1:0]  oh_q, oh_d;
    logic             wrap_q, wrap_d;
    logic             cur_on, sel_ok;
    int               k;

    function automatic logic [W-1:0] pick(
        input logic [N_CH*W-1:0] b,
        input logic [SEL_W-1:0]  i
    );
        pick = '0;
        for (int c = 0; c < N_CH; c++)
            if (SEL_W'(c) == i) pick = b[c*W +: W];
    endfunction

    function automatic logic [N_CH-1:0] onehot(input logic [SEL_W-1:0] i);
        onehot = '0;
        for (int c = 0; c < N_CH; c++)
            if (SEL_W'(c) == i) onehot[c] = 1'b1;
    endfunction

    assign cur_on = |(bus.ch_mask & onehot(idx_q));
    assign sel_ok = int'(bus.sel) < N_CH;

    // first enabled channel after idx_q, circular; smallest step wins
    always_comb begin
        nxt_idx = idx_q;
        k = 0;
        for (int i = N_CH; i >= 1; i--) begin
            k = (int'(idx_q) + i) % N_CH;
            if (bus.ch_mask[k]) nxt_idx = SEL_W'(k);
        end
    end

    always_comb begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = idx_q;
        out_d   = '0;
        oh_d    = '0;
        wrap_d  = 1'b0;
        if (bus.en) state_d = bus.mode ? SCAN : MANUAL;
        unique case (state_d)
            IDLE: ;
            MANUAL: begin
                if (sel_ok) begin
                    idx_d = bus.sel;
                    out_d = pick(bus.in_bus, bus.sel);
                    oh_d  = onehot(bus.sel);
                end
            end
            SCAN: begin
                if (bus.ch_mask == '0) begin
                    idx_d = idx_q;
                end else if (!cur_on) begin
                    // active channel just got masked: blank one clock while moving on
                    idx_d  = nxt_idx;
                    wrap_d = (nxt_idx <= idx_q);
                end else begin
                    if (state_q == SCAN && cnt_q == CNT_LAST) begin
                        idx_d  = nxt_idx;
                        wrap_d = (nxt_idx <= idx_q);
                    end else if (state_q == SCAN) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    out_d = pick(bus.in_bus, idx_d);
                    oh_d  = onehot(idx_d);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            oh_q    <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            oh_q    <= oh_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.ch_onehot = oh_q;
    assign bus.ch_idx    = idx_q;
    assign bus.wrap      = wrap_q;
endmodule
